// File: rtl/fft_pkg.sv
// Shared FFT types and sizes: Q8.8 complex sample, 8-point frame geometry.
// Reused by the input frame buffer, the FFT core and the output serializer.
package fft_pkg;

  localparam int SAMPLE_W = 16;
  localparam int N_POINTS = 8;
  localparam int IDX_W    = 3;
  localparam int FRAC_W   = 8;

  // 'real' is a reserved word, so the components are re/im.
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/fft_in_bank.sv
// One frame bank: 8 complex sample registers plus the EMPTY/FILLING/FULL state.
// The state is a port so the parent and any bound checker see the same value.
module fft_in_bank
  import fft_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  cplx_t                        wr_data,
  input  logic                         wr_done,
  input  logic                         wr_drop,
  input  logic                         rd_take,
  output bank_state_e                  state,
  output logic [N_POINTS*SAMPLE_W-1:0] rd_real,
  output logic [N_POINTS*SAMPLE_W-1:0] rd_imag
);

  bank_state_e state_q, state_d;
  cplx_t       mem_q [N_POINTS];
  cplx_t       mem_d [N_POINTS];

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
      if (wr_drop)      state_d = BANK_EMPTY;
      else if (wr_done) state_d = BANK_FULL;
      else              state_d = BANK_FILLING;
    end
    if (rd_take) state_d = BANK_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BANK_EMPTY;
      for (int k = 0; k < N_POINTS; k++) mem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    rd_real = '0;
    rd_imag = '0;
    for (int k = 0; k < N_POINTS; k++) begin
      rd_real[k*SAMPLE_W +: SAMPLE_W] = mem_q[k].re;
      rd_imag[k*SAMPLE_W +: SAMPLE_W] = mem_q[k].im;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/fft_in_frame_buffer.sv
// Serial-to-parallel frame buffer feeding the 8-point FFT. Define
// FFT_IN_PINGPONG_EN for two alternating banks; otherwise a single bank stalls input.
//
// Handshakes: a transfer happens at a rising edge where valid && ready are both 1;
// ready never depends combinationally on valid, and valid/data hold until accepted.
module fft_in_frame_buffer
  import fft_pkg::*;
#(
  parameter int IN_SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [SAMPLE_W-1:0]          s_real,
  input  logic [SAMPLE_W-1:0]          s_imag,
  input  logic                         s_last,
  output logic                         f_valid,
  input  logic                         f_ready,
  output logic [N_POINTS*SAMPLE_W-1:0] f_real,
  output logic [N_POINTS*SAMPLE_W-1:0] f_imag,
  output logic                         sync_err
);

`ifdef FFT_IN_PINGPONG_EN
  localparam int N_BANKS = 2;
`else
  localparam int N_BANKS = 1;
`endif

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             sync_err_q, sync_err_d;

  logic  accept, last_slot, frame_done, drop, take;
  logic  wr_full, rd_full;
  cplx_t wr_data;

  bank_state_e                  bank_state [N_BANKS];
  logic [N_BANKS-1:0]           bank_full;
  logic [N_POINTS*SAMPLE_W-1:0] bank_real  [N_BANKS];
  logic [N_POINTS*SAMPLE_W-1:0] bank_imag  [N_BANKS];

  // Arithmetic shift per component: sign-extending, rounds toward -inf.
  assign wr_data.re = $signed(s_real) >>> IN_SHIFT;
  assign wr_data.im = $signed(s_imag) >>> IN_SHIFT;

`ifdef FFT_IN_PINGPONG_EN
  assign wr_full = bank_full[wr_bank_q];
  assign rd_full = bank_full[rd_bank_q];
  assign f_real  = bank_real[rd_bank_q];
  assign f_imag  = bank_imag[rd_bank_q];
`else
  assign wr_full = bank_full[0];
  assign rd_full = bank_full[0];
  assign f_real  = bank_real[0];
  assign f_imag  = bank_imag[0];
`endif

  assign s_ready  = !wr_full;
  assign f_valid  = rd_full;
  assign sync_err = sync_err_q;

  always_comb begin
    accept     = s_valid && s_ready;
    last_slot  = (idx_q == IDX_W'(N_POINTS - 1));
    frame_done = accept && last_slot;
    drop       = accept && s_last && !last_slot;
    take       = f_valid && f_ready;

    idx_d = idx_q;
    if (accept) idx_d = (frame_done || drop) ? '0 : idx_q + 1'b1;

    // Early s_last and a missing s_last on slot 7 are both framing errors.
    sync_err_d = accept && (s_last ^ last_slot);

`ifdef FFT_IN_PINGPONG_EN
    wr_bank_d = wr_bank_q ^ frame_done;
    rd_bank_d = rd_bank_q ^ take;
`else
    wr_bank_d = 1'b0;
    rd_bank_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      sync_err_q <= sync_err_d;
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    localparam logic BID = 1'(b);

    fft_in_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (accept && (wr_bank_q == BID)),
      .wr_idx  (idx_q),
      .wr_data (wr_data),
      .wr_done (last_slot),
      .wr_drop (s_last && !last_slot),
      .rd_take (take && (rd_bank_q == BID)),
      .state   (bank_state[b]),
      .rd_real (bank_real[b]),
      .rd_imag (bank_imag[b])
    );

    assign bank_full[b] = (bank_state[b] == BANK_FULL);
  end

endmodule

// File: tb/tb_fft_in_frame_buffer.sv
// Scoreboard bench for fft_in_frame_buffer; a second instance with IN_SHIFT=3
// shares all stimulus so the capture shift is checked on every frame.
module tb_fft_in_frame_buffer;
  import fft_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         f_ready = 1'b0;
  logic [15:0]  s_real = '0;
  logic [15:0]  s_imag = '0;

  logic         s_ready, f_valid, sync_err;
  logic [127:0] f_real, f_imag;
  logic         s_ready3, f_valid3, sync_err3;
  logic [127:0] f_real3, f_imag3;

  fft_in_frame_buffer #(.IN_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
    .f_valid(f_valid), .f_ready(f_ready), .f_real(f_real), .f_imag(f_imag),
    .sync_err(sync_err)
  );

  fft_in_frame_buffer #(.IN_SHIFT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready3),
    .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
    .f_valid(f_valid3), .f_ready(f_ready), .f_real(f_real3), .f_imag(f_imag3),
    .sync_err(sync_err3)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [255:0] exp_q[$];
  logic [255:0] exp3_q[$];
  int vec_cnt = 0, miss_cnt = 0;
  int err_exp = 0, err_seen = 0, frames_seen = 0;
  int m_idx = 0;
  logic [15:0] m_r [8];
  logic [15:0] m_i [8];
  bit burst = 0, ready_dropped = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pack_frame(input int sh);
    logic [127:0] r, i;
    for (int k = 0; k < 8; k++) begin
      r[16*k +: 16] = 16'($signed(m_r[k]) >>> sh);
      i[16*k +: 16] = 16'($signed(m_i[k]) >>> sh);
    end
    return {r, i};
  endfunction

  task automatic model_accept(input logic [15:0] r, input logic [15:0] i, input logic l);
    m_r[m_idx] = r;
    m_i[m_idx] = i;
    if (m_idx == 7) begin
      exp_q.push_back(pack_frame(0));
      exp3_q.push_back(pack_frame(3));
      if (!l) err_exp++;
      m_idx = 0;
    end else if (l) begin
      err_exp++;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (sync_err) err_seen++;
      if (burst && !s_ready) ready_dropped = 1;
      if (f_valid && f_ready) begin
        frames_seen++;
        if (exp_q.size() == 0) begin
          vec_cnt++; miss_cnt++;
          $display("FAIL frame_unexpected: got frame %0h expected none", f_real);
        end else begin
          check("frame", {f_real, f_imag}, exp_q.pop_front());
        end
      end
      if (f_valid3 && f_ready) begin
        if (exp3_q.size() == 0) begin
          vec_cnt++; miss_cnt++;
          $display("FAIL frame3_unexpected: got frame %0h expected none", f_real3);
        end else begin
          check("frame_shift3", {f_real3, f_imag3}, exp3_q.pop_front());
        end
      end
    end
  end

  // drivers
  task automatic send(input logic [15:0] r, input logic [15:0] i, input logic l);
    int n = 0;
    s_valid = 1'b1; s_real = r; s_imag = i; s_last = l;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      vec_cnt++; miss_cnt++;
      $display("FAIL send_timeout: s_ready %0b after %0d cycles, required 1", s_ready, n);
      s_valid = 1'b0; s_last = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(r, i, l);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int k = 0; k < 8; k++) send(16'(base + k * 16'h0100), 16'(-(base + k * 16'h0100)), k == 7);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp3_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp3_q.size() != 0) begin
      vec_cnt++; miss_cnt++;
      $display("FAIL drain_timeout: %0d frames pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    logic [127:0] hr, hi;
    int fs;

    // reset state
    #2;
    check("rst_s_ready", 256'(s_ready), 256'(1));
    check("rst_f_valid", 256'(f_valid), 256'(0));
    check("rst_f_real", 256'(f_real), 256'(0));
    check("rst_f_imag", 256'(f_imag), 256'(0));
    check("rst_sync_err", 256'(sync_err), 256'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic frame, f_ready high
    f_ready = 1'b1;
    send_frame(0);
    check("t1_f_valid", 256'(f_valid), 256'(1));
    for (int k = 0; k < 8; k++) begin
      hr[16*k +: 16] = 16'(k * 16'h0100);
      hi[16*k +: 16] = 16'(-(k * 16'h0100));
    end
    check("t1_f_real", 256'(f_real), 256'(hr));
    check("t1_f_imag", 256'(f_imag), 256'(hi));
    @(negedge clk);
    check("t1_no_sync_err", 256'(err_seen), 256'(0));

    // capture shift
    send(16'h8000, 16'h0800, 1'b0);
    for (int k = 1; k < 8; k++) send(16'(k * 16'h0010), 16'(k), k == 7);
    check("t2_shift3_real0", 256'(f_real3[15:0]), 256'(16'hF000));
    check("t2_shift3_imag0", 256'(f_imag3[15:0]), 256'(16'h0100));
    check("t2_shift0_real0", 256'(f_real[15:0]), 256'(16'h8000));
    drain();

    // early s_last discards partial frame
    for (int k = 0; k < 5; k++) send(16'(16'h0700 + k), 16'(k), k == 4);
    repeat (3) @(negedge clk);
    check("t3_sync_err_count", 256'(err_seen), 256'(1));
    check("t3_no_f_valid", 256'(f_valid), 256'(0));
    send_frame(16'h0040);
    check("t3_slot0_real", 256'(f_real[15:0]), 256'(16'h0040));
    drain();

    // consumer stalls
    f_ready = 1'b0;
    send_frame(16'h0003);
`ifdef FFT_IN_PINGPONG_EN
    send_frame(16'h0005);
    check("t4_pp_s_ready_low", 256'(s_ready), 256'(0));
    repeat (20) @(negedge clk);
`else
    repeat (20) @(negedge clk);
    check("t4_single_s_ready_low", 256'(s_ready), 256'(0));
`endif
    check("t4_f_valid_held", 256'(f_valid), 256'(1));
    hr[15:0] = 16'h0003;
    hr[127:112] = 16'h0703;
    check("t4_held_slot0", 256'(f_real[15:0]), 256'(hr[15:0]));
    check("t4_held_slot7", 256'(f_real[127:112]), 256'(hr[127:112]));
    f_ready = 1'b1;
    drain();
    check("t4_s_ready_back", 256'(s_ready), 256'(1));

    // sustained burst of 64 samples
    fs = frames_seen;
`ifdef FFT_IN_PINGPONG_EN
    burst = 1;
`endif
    for (int j = 0; j < 64; j++) send(16'(j * 3), 16'(~j), (j % 8) == 7);
    burst = 0;
    drain();
    check("t5_frames", 256'(frames_seen - fs), 256'(8));
    check("t5_ready_never_dropped", 256'(ready_dropped), 256'(0));

    // reset mid-frame
    for (int k = 0; k < 5; k++) send(16'(16'h1100 + k), 16'(k), 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_s_ready", 256'(s_ready), 256'(1));
    check("t6_f_valid", 256'(f_valid), 256'(0));
    check("t6_f_real", 256'(f_real), 256'(0));
    check("t6_f_imag", 256'(f_imag), 256'(0));
    check("t6_sync_err", 256'(sync_err), 256'(0));
    m_idx = 0;
    exp_q.delete();
    exp3_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fs = frames_seen;
    send_frame(16'h0020);
    check("t6_slot0_real", 256'(f_real[15:0]), 256'(16'h0020));
    drain();
    check("t6_frames", 256'(frames_seen - fs), 256'(1));

    repeat (2) @(negedge clk);
    check("sync_err_total", 256'(err_seen), 256'(err_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/fft_in_frame_buffer.md
# fft_in_frame_buffer

Serial-to-parallel frame buffer upstream of the 8-point radix-2 FFT core. Accepts one complex Q8.8 sample per handshake and collects 8 consecutive samples into a frame. Presents the frame to the FFT's in0..in7 ports as flattened buses, holding them stable until the consumer acknowledges. Optionally ping-pongs between two banks so input streaming continues while a frame is held.

## Interface
- IN_SHIFT, 0: arithmetic right shift (0..3) applied to each sample on capture; 3 pre-scales by 1/8 against 3-stage growth
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  buffer can accept a sample
- s_real  in  16  sample real part, signed Q8.8
- s_imag  in  16  sample imag part, signed Q8.8
- s_last  in  1  marks final sample of a frame
- f_valid  out  1  complete frame presented
- f_ready  in  1  FFT side consumes frame
- f_real  out  128  frame real parts; sample k at [16k+15:16k], k = arrival order 0..7, maps to in{k}_real
- f_imag  out  128  frame imag parts, same packing
- sync_err  out  1  one-cycle pulse on framing error

## Operation
- Sample accepted when s_valid && s_ready at a rising edge; written to the write bank at the write index; index increments.
- Stored value = {s_real, s_imag} >>> IN_SHIFT per component (sign-extending, truncation toward -inf).
- Index 7 accepted: bank marked full; index wraps to 0; write bank switches (ping-pong) or stalls (single).
- s_last at index 7: normal. s_last at index 0..6: partial frame discarded, index reset to 0, bank stays empty, sync_err pulses next cycle. Index 7 without s_last: frame still completes, sync_err pulses next cycle.
- Read side per bank state: EMPTY -> FILLING (first sample) -> FULL (8th sample) -> EMPTY (f_valid && f_ready).
- f_valid = read bank FULL; f_real/f_imag driven from read bank registers, stable while f_valid && !f_ready.
- Frames leave in arrival order; no frame dropped or duplicated.
- s_ready = write bank not FULL; register-derived only, no combinational path from f_ready or s_valid.

## Timing
- Reset values: s_ready 1, f_valid 0, f_real 0, f_imag 0, sync_err 0; index 0, all banks EMPTY, write and read bank 0.
- Reset mid-frame: partial frame and any held frame discarded asynchronously.
- Latency: 8th sample accepted at edge N -> f_valid 1 after edge N.
- Single bank: s_ready 0 after edge N; frame consumed at edge M -> s_ready 1 after edge M. Back-to-back throughput 8 samples per 9 cycles minimum.
- Ping-pong: s_ready 0 only when both banks FULL; sustained 1 sample/cycle with f_ready held 1.
- Same-edge frame completion on one bank and consumption of the other: both take effect.
- Both banks full, consumption at edge M -> s_ready 1 after edge M.

## Configuration
- FFT_IN_PINGPONG_EN defined: two banks, alternating write/read pointers as above.
- Undefined: one bank; write and read pointers fixed at 0; s_ready low from frame completion until consumption. Port list identical in both builds.

## Structure
- Shared fft_pkg: SAMPLE_W = 16, N_POINTS = 8, IDX_W = 3, FRAC_W = 8, typedef cplx_t {real, imag} signed SAMPLE_W each; reused by FFT core and downstream serializer.
- Sub-module fft_in_bank: 8 x cplx_t register file with write strobe/index, full flag, set/clear; instantiated once or twice under FFT_IN_PINGPONG_EN.

## Test plan
- Reset, send samples k=0..7 with real = k*0x0100, imag = -k*0x0100, s_last on 7, f_ready 1 -> f_valid one cycle after 8th sample; f_real[16k+15:16k] = k*0x0100; sync_err never pulses.
- IN_SHIFT=3, sample real 0x8000, imag 0x0800 -> stored 0xF000, 0x0100.
- s_last on sample 4 -> sync_err pulse, no f_valid; next 8 samples form a clean frame with sample 0 at slot 0.
- f_ready held 0 for 20 cycles after frame: single bank -> s_ready 0, f_real stable; ping-pong -> second frame accepted, s_ready 0 after its 8th sample, frames delivered in order once f_ready 1.
- Ping-pong, f_ready 1, 64 samples back-to-back -> s_ready never drops, 8 frames delivered.
- Assert rst_n low after 5 samples -> all outputs at reset values immediately; next 8 samples form a full frame.
